// File: rtl/vga_pkg.sv
// Shared defaults for the 640x480@60 raster and the 12-bit colour word layout.
// The board renderer and its timing generator both import this package.
package vga_pkg;

    localparam int DEF_PIX_DIV  = 2;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;

    localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
    localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;

    // Palette entries and pin colour share this {r,g,b} layout.
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider and h/v raster counters with raw sync, active and frame markers.
// Everything downstream advances only when tick is high.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT
) (
    input  logic clock,
    input  logic reset,
    output logic tick,
    output logic frame_start,
    output logic line_end,
    output logic frame_end,
    output logic h_active,
    output logic v_active,
    output logic hs,
    output logic vs
);

    localparam int HT = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int VT = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    logic [DW-1:0] div_reg;
    logic [HW-1:0] h_reg;
    logic [VW-1:0] v_reg;

    always_comb begin
        tick        = (div_reg == DW'(PIX_DIV - 1));
        line_end    = tick && (h_reg == HW'(HT - 1));
        frame_end   = line_end && (v_reg == VW'(VT - 1));
        frame_start = tick && (h_reg == '0) && (v_reg == '0);
        hs          = (h_reg < HW'(H_SYNC));
        vs          = (v_reg < VW'(V_SYNC));
        h_active    = (h_reg >= HW'(H_SYNC + H_BACK)) && (h_reg < HW'(H_SYNC + H_BACK + H_ACTIVE));
        v_active    = (v_reg >= VW'(V_SYNC + V_BACK)) && (v_reg < VW'(V_SYNC + V_BACK + V_ACTIVE));
    end

    // v only moves on a line wrap, so a frame never ends mid-line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_reg <= '0;
            h_reg   <= '0;
            v_reg   <= '0;
        end else begin
            div_reg <= tick ? '0 : div_reg + 1'b1;
            if (tick) begin
                h_reg <= line_end ? '0 : h_reg + 1'b1;
            end
            if (line_end) begin
                v_reg <= frame_end ? '0 : v_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile-board VGA renderer: cell counters, frame-start board snapshot and a
// two-tick index/palette pipeline that keeps colour and sync aligned.
module vga_tile_renderer
    import vga_pkg::*;
#(
    parameter int PIX_DIV   = DEF_PIX_DIV,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int GRID_COLS = 16,
    parameter int GRID_ROWS = 12,
    parameter int CELL_W    = 40,
    parameter int CELL_H    = 40,
    parameter int CELL_BITS = 2,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [GRID_COLS*GRID_ROWS*CELL_BITS-1:0] data,
    input  logic [12*(2**CELL_BITS)-1:0]          palette,
    output logic                                  hSync,
    output logic                                  vSync,
    output logic [3:0]                            r,
    output logic [3:0]                            g,
    output logic [3:0]                            b,
    output logic                                  frame_start
);

    localparam int NCELLS     = GRID_COLS * GRID_ROWS;
    localparam int NPAL       = 2 ** CELL_BITS;
    localparam int CELL_IDX_W = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam int COL_W      = $clog2(GRID_COLS + 1);
    localparam int ROW_W      = $clog2(GRID_ROWS + 1);
    localparam int X_W        = $clog2(CELL_W + 1);
    localparam int Y_W        = $clog2(CELL_H + 1);

    if (GRID_COLS * CELL_W > H_ACTIVE || GRID_ROWS * CELL_H > V_ACTIVE) begin : g_bad_board
        $error("vga_tile_renderer: board does not fit inside the active area");
    end
    if (PIX_DIV < 2) begin : g_bad_div
        $error("vga_tile_renderer: PIX_DIV must be at least 2");
    end

    logic tick, line_end, frame_end, h_active, v_active, hs, vs;

    vga_timing_gen #(
        .PIX_DIV (PIX_DIV),
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_ACTIVE(H_ACTIVE),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_ACTIVE(V_ACTIVE),
        .V_FRONT (V_FRONT)
    ) u_timing (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .frame_start(frame_start),
        .line_end   (line_end),
        .frame_end  (frame_end),
        .h_active   (h_active),
        .v_active   (v_active),
        .hs         (hs),
        .vs         (vs)
    );

    logic [COL_W-1:0] col_reg;
    logic [X_W-1:0]   x_reg;
    logic [ROW_W-1:0] row_reg;
    logic [Y_W-1:0]   y_reg;

    // Counters are held at zero through blanking so they describe the current pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_reg <= '0;
            x_reg   <= '0;
        end else if (tick) begin
            if (!h_active) begin
                col_reg <= '0;
                x_reg   <= '0;
            end else if (x_reg == X_W'(CELL_W - 1)) begin
                x_reg <= '0;
                if (col_reg != COL_W'(GRID_COLS)) col_reg <= col_reg + 1'b1;
            end else begin
                x_reg <= x_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_reg <= '0;
            y_reg   <= '0;
        end else if (frame_end) begin
            row_reg <= '0;
            y_reg   <= '0;
        end else if (line_end && v_active) begin
            if (y_reg == Y_W'(CELL_H - 1)) begin
                y_reg <= '0;
                if (row_reg != ROW_W'(GRID_ROWS)) row_reg <= row_reg + 1'b1;
            end else begin
                y_reg <= y_reg + 1'b1;
            end
        end
    end

    logic [CELL_BITS-1:0] snapshot [NCELLS];
    rgb12_t               pal [NPAL];

    for (genvar gi = 0; gi < NCELLS; gi++) begin : g_snap
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                snapshot[gi] <= '0;
            end else if (frame_start) begin
                snapshot[gi] <= data[gi*CELL_BITS +: CELL_BITS];
            end
        end
    end

    for (genvar gi = 0; gi < NPAL; gi++) begin : g_pal
        assign pal[gi] = palette[12*gi +: 12];
    end

    logic                  in_board;
    logic [CELL_IDX_W-1:0] cell_sel;

    always_comb begin
        in_board = (col_reg < COL_W'(GRID_COLS)) && (row_reg < ROW_W'(GRID_ROWS));
        cell_sel = '0;
        if (in_board) begin
            cell_sel = CELL_IDX_W'(int'(row_reg) * GRID_COLS + int'(col_reg));
        end
    end

    logic [CELL_BITS-1:0] index1_reg;
    logic                 show1_reg;
    logic                 hs1_reg, vs1_reg;
    rgb12_t               rgb_reg;
    logic                 hsync_reg, vsync_reg;

    // Stage 1 resolves the cell index, stage 2 looks up the live palette.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index1_reg <= '0;
            show1_reg  <= 1'b0;
            hs1_reg    <= 1'b0;
            vs1_reg    <= 1'b0;
            rgb_reg    <= '0;
            hsync_reg  <= ~SYNC_POL;
            vsync_reg  <= ~SYNC_POL;
        end else if (tick) begin
            index1_reg <= snapshot[cell_sel];
            show1_reg  <= in_board && h_active && v_active;
            hs1_reg    <= hs;
            vs1_reg    <= vs;
            rgb_reg    <= show1_reg ? pal[index1_reg] : '0;
            hsync_reg  <= hs1_reg ? SYNC_POL : ~SYNC_POL;
            vsync_reg  <= vs1_reg ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign hSync = hsync_reg;
    assign vSync = vsync_reg;
    assign r     = rgb_reg.r;
    assign g     = rgb_reg.g;
    assign b     = rgb_reg.b;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Directed bench on a shrunken raster (25 ticks x 17 lines, 4x3 board of 4x4 cells)
// plus a narrower 3-column board to exercise the right-hand margin.
module tb_vga_tile_renderer;

    localparam int HT = 25;    // 4 sync + 3 back + 16 active + 2 front
    localparam int VT = 17;    // 2 sync + 2 back + 12 active + 1 front
    localparam int FRAME = HT * VT;

    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] data;
    logic [17:0] data2;
    logic [47:0] palette;

    logic       hSync, vSync, frame_start;
    logic [3:0] r, g, b;
    logic       hs2, vs2, fs2;
    logic [3:0] r2, g2, b2;

    int n_vec = 0;
    int n_bad = 0;
    int cur   = 0;

    always #5 clock = ~clock;

    vga_tile_renderer #(
        .PIX_DIV(2), .H_SYNC(4), .H_BACK(3), .H_ACTIVE(16), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(12), .V_FRONT(1),
        .GRID_COLS(4), .GRID_ROWS(3), .CELL_W(4), .CELL_H(4), .CELL_BITS(2), .SYNC_POL(1'b0)
    ) dut (
        .clock(clock), .reset(reset), .data(data), .palette(palette),
        .hSync(hSync), .vSync(vSync), .r(r), .g(g), .b(b), .frame_start(frame_start)
    );

    vga_tile_renderer #(
        .PIX_DIV(2), .H_SYNC(4), .H_BACK(3), .H_ACTIVE(16), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(12), .V_FRONT(1),
        .GRID_COLS(3), .GRID_ROWS(3), .CELL_W(4), .CELL_H(4), .CELL_BITS(2), .SYNC_POL(1'b0)
    ) dut2 (
        .clock(clock), .reset(reset), .data(data2), .palette(palette),
        .hSync(hs2), .vSync(vs2), .r(r2), .g(g2), .b(b2), .frame_start(fs2)
    );

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %-12s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %-12s got=%h", tag, got);
        end
    endtask

    // Counts negedges until frame_start is seen; cur restarts at that frame-start cycle.
    task automatic wait_fs(input string tag, input int expected);
        int n = 0;
        while (1) begin
            @(negedge clock);
            n++;
            if (frame_start || n >= 40) break;
        end
        check(tag, 12'(n), 12'(expected));
        cur = 0;
    endtask

    task automatic goto_cyc(input int target);
        while (cur < target) begin
            @(negedge clock);
            cur++;
        end
    endtask

    // Pixel (h,v) of frame f reaches the pins 2 ticks after its counter position.
    task automatic goto_pos(input int h, input int v, input int f);
        goto_cyc(2 * (f * FRAME + v * HT + h) + 3);
    endtask

    initial begin
        reset   = 1'b1;
        data    = 24'h0C0081;  // cell(0,0)=1, cell(3,0)=2, cell(1,2)=3
        data2   = 18'h3FFFF;
        palette = {12'hF00, 12'h0F0, 12'hFFF, 12'h000};
        repeat (3) @(posedge clock);
        #1;
        check("rst_rgb",   {r, g, b},          12'h000);
        check("rst_hsync", 12'(hSync),         12'h001);
        check("rst_vsync", 12'(vSync),         12'h001);
        check("rst_fs",    12'(frame_start),   12'h000);

        @(posedge clock);
        #1 reset = 1'b0;
        wait_fs("fs_first", 2);

        goto_pos(6, 4, 0);   check("back_porch", {r, g, b}, 12'h000);
        goto_pos(7, 4, 0);   check("c00_first",  {r, g, b}, 12'hFFF);
                             check("b2_first",   {r2, g2, b2}, 12'hF00);
        goto_pos(10, 4, 0);  check("c00_last",   {r, g, b}, 12'hFFF);
        goto_pos(11, 4, 0);  check("c10",        {r, g, b}, 12'h000);
        goto_pos(22, 4, 0);  check("c30",        {r, g, b}, 12'h0F0);
        goto_pos(23, 4, 0);  check("front",      {r, g, b}, 12'h000);
        goto_pos(3, 5, 0);   check("hs_on",      12'(hSync), 12'h000);
                             check("b2_hs_on",   12'(hs2),   12'h000);
        goto_pos(4, 5, 0);   check("hs_off",     12'(hSync), 12'h001);
        goto_pos(18, 6, 0);  check("b2_col2",    {r2, g2, b2}, 12'hF00);
        goto_pos(19, 6, 0);  check("b2_margin",  {r2, g2, b2}, 12'h000);
        goto_pos(7, 7, 0);   check("row0_last",  {r, g, b}, 12'hFFF);
        goto_pos(7, 8, 0);   check("row1_first", {r, g, b}, 12'h000);

        data = 24'h000002;   // mid-frame: cell(0,0)=2, everything else 0
        goto_pos(12, 13, 0); check("old_c12",    {r, g, b}, 12'hF00);
        goto_pos(12, 16, 0); check("v_front",    {r, g, b}, 12'h000);
        goto_cyc(2 * FRAME - 1); check("fs_gap",  12'(frame_start), 12'h000);
        goto_cyc(2 * FRAME);     check("fs_next", 12'(frame_start), 12'h001);

        goto_pos(5, 1, 1);   check("vs_on",      12'(vSync), 12'h000);
                             check("b2_vs_on",   12'(vs2),   12'h000);
        goto_pos(5, 2, 1);   check("vs_off",     12'(vSync), 12'h001);
        goto_pos(7, 4, 1);   check("new_c00",    {r, g, b}, 12'h0F0);
        goto_pos(8, 5, 1);   check("pre_rst",    {r, g, b}, 12'h0F0);

        reset = 1'b1;
        #1;
        check("mid_rgb",   {r, g, b},  12'h000);
        check("mid_hsync", 12'(hSync), 12'h001);
        check("mid_vsync", 12'(vSync), 12'h001);
        check("mid_fs2",   12'(fs2),   12'h000);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        wait_fs("fs_restart", 2);

        goto_pos(7, 4, 0);   check("rs_c00",     {r, g, b}, 12'h0F0);
        goto_pos(12, 13, 0); check("rs_c12",     {r, g, b}, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
